// File: rtl/program_loader.sv
//============================================================================
// Module      : program_loader
// Description : Boot-time loader for SINGLE_CORE. Takes a valid/ready stream
//               of 32-bit instruction words and writes them to instruction
//               memory from a base address. It then releases the core at that
//               start PC and counts run cycles until the core signals end.
//               Optional run-cycle watchdog: define PROGRAM_LOADER_WDOG_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module program_loader #(
    parameter int MAX_INS  = 64,
    parameter int WDOG_MAX = 4096,
    localparam int CW      = $clog2(MAX_INS + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [31:0]   initial_pc_in,
    input  logic          load_start_in,
    input  logic          ins_valid_in,
    input  logic [31:0]   ins_data_in,
    input  logic          ins_last_in,
    output logic          ins_ready_out,
    output logic          mem_write_en_out,
    output logic [31:0]   mem_addr_out,
    output logic [31:0]   mem_data_out,
    output logic          core_run_out,
    output logic [31:0]   initial_pc_out,
    input  logic          end_signal_in,
    output logic [CW-1:0] ins_count_out,
    output logic [31:0]   cycle_count_out,
    output logic          done_out,
    output logic          error_out
);

`ifdef PROGRAM_LOADER_WDOG_EN
    localparam logic c_WDOG_EN = 1'b1;
`else
    localparam logic c_WDOG_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_ready;
    logic          r_wr_en;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic          r_run;
    logic [31:0]   r_pc_out;
    logic [31:0]   r_base;
    logic [CW-1:0] r_ins_count;
    logic [31:0]   r_cycle_count;
    logic          r_done;
    logic          r_error;
    logic          r_seen_low;

    logic          w_xfer;
    logic          w_at_limit;
    logic          w_end;
    logic          w_wdog;

    // A word is taken only while loading and advertising ready.
    assign w_xfer     = (r_state == S_LOAD) && ins_valid_in && r_ready;
    // The word taken at this count is the last one that fits.
    assign w_at_limit = (r_ins_count == CW'(MAX_INS - 1));
    // End counts only after end_signal_in has been seen low during this run,
    // so a level left high from a previous program is not mistaken for end.
    assign w_end      = r_seen_low && end_signal_in;
    // Fires on the cycle whose increment brings the run count to WDOG_MAX.
    assign w_wdog     = c_WDOG_EN && (r_cycle_count == 32'(WDOG_MAX - 1));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode. On the same cycle, end takes priority over the watchdog.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_start_in) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    if (ins_last_in) begin
                        w_next = S_RELEASE;
                    end else if (w_at_limit) begin
                        w_next = S_ERROR;
                    end
                end
            end
            S_RELEASE: w_next = S_RUN;
            S_RUN: begin
                if (w_end) begin
                    w_next = S_DONE;
                end else if (w_wdog) begin
                    w_next = S_ERROR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Registered datapath and outputs: memory write port, core release, counters, status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ready       <= 1'b0;
            r_wr_en       <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_run         <= 1'b0;
            r_pc_out      <= '0;
            r_base        <= '0;
            r_ins_count   <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_seen_low    <= 1'b0;
        end else begin
            r_ready <= (w_next == S_LOAD);
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_addr      <= r_base + 32'(r_ins_count);
                r_data      <= ins_data_in;
                r_ins_count <= r_ins_count + CW'(1);
            end
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (load_start_in) begin
                        r_base        <= initial_pc_in;
                        r_ins_count   <= '0;
                        r_cycle_count <= '0;
                        r_done        <= 1'b0;
                        r_error       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_xfer && !ins_last_in && w_at_limit) begin
                        r_error <= 1'b1;
                    end
                end
                // One spare cycle here lets the final memory write land before the core fetches.
                S_RELEASE: begin
                    r_pc_out   <= r_base;
                    r_run      <= 1'b1;
                    r_seen_low <= 1'b0;
                end
                S_RUN: begin
                    if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + 32'd1;
                    end
                    r_seen_low <= r_seen_low | ~end_signal_in;
                    if (w_end) begin
                        r_run  <= 1'b0;
                        r_done <= 1'b1;
                    end else if (w_wdog) begin
                        r_run   <= 1'b0;
                        r_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ins_ready_out    = r_ready;
    assign mem_write_en_out = r_wr_en;
    assign mem_addr_out     = r_addr;
    assign mem_data_out     = r_data;
    assign core_run_out     = r_run;
    assign initial_pc_out   = r_pc_out;
    assign ins_count_out    = r_ins_count;
    assign cycle_count_out  = r_cycle_count;
    assign done_out         = r_done;
    assign error_out        = r_error;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
//============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Every accepted word
//               pushes its expected address/data to a scoreboard, which is
//               compared against the memory write strobes.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_program_loader;

    localparam int MAX_INS = 12;
    localparam int CW      = $clog2(MAX_INS + 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   initial_pc_in = '0;
    logic          load_start_in = 1'b0;
    logic          ins_valid_in = 1'b0;
    logic [31:0]   ins_data_in = '0;
    logic          ins_last_in = 1'b0;
    logic          ins_ready_out;
    logic          mem_write_en_out;
    logic [31:0]   mem_addr_out;
    logic [31:0]   mem_data_out;
    logic          core_run_out;
    logic [31:0]   initial_pc_out;
    logic          end_signal_in = 1'b0;
    logic [CW-1:0] ins_count_out;
    logic [31:0]   cycle_count_out;
    logic          done_out;
    logic          error_out;

    int            checks = 0;
    int            failures = 0;
    int            n_writes = 0;
    logic [63:0]   exp_q[$];
    logic [63:0]   mon_exp;

    program_loader #(.MAX_INS(MAX_INS), .WDOG_MAX(4096)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .initial_pc_in    (initial_pc_in),
        .load_start_in    (load_start_in),
        .ins_valid_in     (ins_valid_in),
        .ins_data_in      (ins_data_in),
        .ins_last_in      (ins_last_in),
        .ins_ready_out    (ins_ready_out),
        .mem_write_en_out (mem_write_en_out),
        .mem_addr_out     (mem_addr_out),
        .mem_data_out     (mem_data_out),
        .core_run_out     (core_run_out),
        .initial_pc_out   (initial_pc_out),
        .end_signal_in    (end_signal_in),
        .ins_count_out    (ins_count_out),
        .cycle_count_out  (cycle_count_out),
        .done_out         (done_out),
        .error_out        (error_out)
    );

    always #5 clock = ~clock;

    // Scoreboard: every write strobe must match the oldest accepted word.
    always @(negedge clock) begin
        if (reset_n && mem_write_en_out) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr_out, mem_data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_addr_out, mem_data_out} !== mon_exp) begin
                    failures++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr_out, mem_data_out, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // Pulse load_start_in; returns at the first negedge in LOAD.
    task automatic start_load(input logic [31:0] pc);
        @(negedge clock);
        initial_pc_in = pc;
        load_start_in = 1'b1;
        @(negedge clock);
        load_start_in = 1'b0;
        initial_pc_in = 32'hDEAD_BEEF;
    endtask

    // Offer n words (random gaps at gap_pct percent) for at most `tries` cycles.
    task automatic send(input logic [31:0] base, input int n, input bit last_final,
                        input int gap_pct, input int tries, output int accepted);
        int k;
        int t;
        logic [31:0] d;
        k = 0;
        t = 0;
        while (k < n && t < tries) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                ins_valid_in = 1'b0;
                ins_last_in  = 1'b0;
            end else begin
                d = $urandom();
                ins_valid_in = 1'b1;
                ins_data_in  = d;
                ins_last_in  = last_final && (k == n - 1);
                if (ins_ready_out) begin
                    exp_q.push_back({base + 32'(k), d});
                    k++;
                end
            end
            t++;
            @(negedge clock);
        end
        ins_valid_in = 1'b0;
        ins_last_in  = 1'b0;
        accepted = k;
    endtask

    // Wait (bounded) for the core to be released; returns at that negedge.
    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (core_run_out === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        load_start_in = 1'b1;
        ins_valid_in = 1'b1;
        initial_pc_in = 32'h1234;
        repeat (3) @(negedge clock);
        checks++;
        if ({ins_ready_out, mem_write_en_out, core_run_out, done_out, error_out} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b, expected 00000",
                     {ins_ready_out, mem_write_en_out, core_run_out, done_out, error_out});
        end
        checks++;
        if ({mem_addr_out, mem_data_out, initial_pc_out, cycle_count_out} !== 128'h0 || ins_count_out !== '0) begin
            failures++;
            $display("FAIL reset_values: got addr=%h data=%h pc=%h cyc=%h cnt=%0d, expected all 0",
                     mem_addr_out, mem_data_out, initial_pc_out, cycle_count_out, ins_count_out);
        end
        load_start_in = 1'b0;
        ins_valid_in = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({ins_ready_out, core_run_out, done_out, error_out} !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle: got %b, expected 0000",
                     {ins_ready_out, core_run_out, done_out, error_out});
        end
    endtask

    task automatic test_factorial_load();
        int acc;
        int w0;
        bit ok;
        end_signal_in = 1'b0;
        w0 = n_writes;
        start_load(32'd14);
        checks++;
        if (ins_ready_out !== 1'b1) begin
            failures++;
            $display("FAIL fact_ready_first_cycle: got %b, expected 1", ins_ready_out);
        end
        send(32'd14, 12, 1'b1, 0, 40, acc);
        checks++;
        if (acc != 12) begin
            failures++;
            $display("FAIL fact_accepted: got %0d, expected 12", acc);
        end
        wait_run(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fact_run_timeout: got core_run_out=0, expected 1");
        end
        checks++;
        if (initial_pc_out !== 32'd14 || ins_count_out !== CW'(12) || ins_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL fact_release: got pc=%0d cnt=%0d ready=%b, expected pc=14 cnt=12 ready=0",
                     initial_pc_out, ins_count_out, ins_ready_out);
        end
        checks++;
        if (n_writes - w0 != 12 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL fact_write_count: got %0d writes, %0d pending, expected 12 and 0",
                     n_writes - w0, exp_q.size());
        end
        repeat (3) @(negedge clock);
        end_signal_in = 1'b1;
        @(negedge clock);
        checks++;
        if (done_out !== 1'b1 || core_run_out !== 1'b0) begin
            failures++;
            $display("FAIL fact_done: got done=%b run=%b, expected done=1 run=0", done_out, core_run_out);
        end
    endtask

    task automatic test_gaps_and_end();
        int acc;
        int w0;
        bit ok;
        end_signal_in = 1'b1;
        w0 = n_writes;
        // Base near the top of the address space so the write address wraps.
        start_load(32'hFFFF_FFFE);
        send(32'hFFFF_FFFE, 5, 1'b1, 40, 300, acc);
        checks++;
        if (acc != 5) begin
            failures++;
            $display("FAIL gaps_accepted: got %0d, expected 5", acc);
        end
        wait_run(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL gaps_run_timeout: got core_run_out=0, expected 1");
        end
        // Negedge j after release: cycle_count == j. End held high on entry, low from j=3, high at j=39.
        for (int j = 0; j < 40; j++) begin
            if (j == 2) begin
                checks++;
                if (done_out !== 1'b0 || core_run_out !== 1'b1) begin
                    failures++;
                    $display("FAIL gaps_high_on_entry: got done=%b run=%b, expected done=0 run=1",
                             done_out, core_run_out);
                end
            end
            end_signal_in = (j < 3 || j == 39);
            @(negedge clock);
        end
        checks++;
        if (done_out !== 1'b1 || core_run_out !== 1'b0 || cycle_count_out !== 32'd40) begin
            failures++;
            $display("FAIL gaps_end: got done=%b run=%b cyc=%0d, expected done=1 run=0 cyc=40",
                     done_out, core_run_out, cycle_count_out);
        end
        checks++;
        if (n_writes - w0 != 5 || exp_q.size() != 0 || ins_count_out !== CW'(5)) begin
            failures++;
            $display("FAIL gaps_writes: got %0d writes cnt=%0d pending=%0d, expected 5 5 0",
                     n_writes - w0, ins_count_out, exp_q.size());
        end
        repeat (3) @(negedge clock);
        checks++;
        if (cycle_count_out !== 32'd40 || done_out !== 1'b1) begin
            failures++;
            $display("FAIL gaps_frozen: got cyc=%0d done=%b, expected cyc=40 done=1",
                     cycle_count_out, done_out);
        end
    endtask

    task automatic test_overflow();
        int acc;
        int w0;
        end_signal_in = 1'b0;
        w0 = n_writes;
        start_load(32'h200);
        checks++;
        if (done_out !== 1'b0 || ins_ready_out !== 1'b1 || cycle_count_out !== 32'd0 || ins_count_out !== '0) begin
            failures++;
            $display("FAIL ovf_restart: got done=%b ready=%b cyc=%0d cnt=%0d, expected 0 1 0 0",
                     done_out, ins_ready_out, cycle_count_out, ins_count_out);
        end
        send(32'h200, MAX_INS + 1, 1'b0, 0, 25, acc);
        checks++;
        if (acc != MAX_INS) begin
            failures++;
            $display("FAIL ovf_accepted: got %0d, expected %0d", acc, MAX_INS);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (error_out !== 1'b1 || ins_count_out !== CW'(MAX_INS) || core_run_out !== 1'b0 || ins_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL ovf_error: got err=%b cnt=%0d run=%b ready=%b, expected 1 %0d 0 0",
                     error_out, ins_count_out, core_run_out, ins_ready_out, MAX_INS);
        end
        checks++;
        if (n_writes - w0 != MAX_INS || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ovf_writes: got %0d writes %0d pending, expected %0d and 0",
                     n_writes - w0, exp_q.size(), MAX_INS);
        end
        start_load(32'h300);
        checks++;
        if (error_out !== 1'b0 || ins_ready_out !== 1'b1 || ins_count_out !== '0 || cycle_count_out !== 32'd0) begin
            failures++;
            $display("FAIL ovf_reload: got err=%b ready=%b cnt=%0d cyc=%0d, expected 0 1 0 0",
                     error_out, ins_ready_out, ins_count_out, cycle_count_out);
        end
    endtask

    // Continues the load started by test_overflow at base 0x300.
    task automatic test_reset_mid_load();
        int acc;
        bit ok;
        send(32'h300, 3, 1'b0, 0, 10, acc);
        @(negedge clock);
        checks++;
        if (acc != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_pre: got acc=%0d pending=%0d, expected 3 0", acc, exp_q.size());
        end
        ins_valid_in = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({ins_ready_out, mem_write_en_out, core_run_out, done_out, error_out} !== 5'b0 ||
            {mem_addr_out, mem_data_out, cycle_count_out} !== 96'h0 || ins_count_out !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: got ready=%b we=%b addr=%h data=%h cnt=%0d, expected all 0",
                     ins_ready_out, mem_write_en_out, mem_addr_out, mem_data_out, ins_count_out);
        end
        ins_valid_in = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        start_load(32'd100);
        send(32'd100, 4, 1'b1, 0, 20, acc);
        wait_run(ok);
        checks++;
        if (!ok || initial_pc_out !== 32'd100 || ins_count_out !== CW'(4) || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_reload: got run=%b pc=%0d cnt=%0d pending=%0d, expected 1 100 4 0",
                     core_run_out, initial_pc_out, ins_count_out, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_factorial_load();
        test_gaps_and_end();
        test_overflow();
        test_reset_mid_load();
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
